// File: rtl/imply_arbiter_pkg.sv
// Shared definitions for the DPLL implication arbiter: default sizes,
// the implication record and the pointer wrap helper.
package imply_arbiter_pkg;

  localparam int NUM_EVAL   = 4;
  localparam int IMPL_VAR_W = 8;
  localparam int IMPL_CNT_W = 16;

  typedef struct packed {
    logic [IMPL_VAR_W-1:0] var_idx;
    logic                  val;
  } implication_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/imply_arbiter_rr_arbiter.sv
// Combinational rotating-priority pick: first valid index at or after ptr_i,
// wrapping to the lowest valid index when nothing lies at or above it.
module imply_arbiter_rr_arbiter
  import imply_arbiter_pkg::*;
#(
  parameter int N     = NUM_EVAL,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Upper pass covers indices at/after the pointer, lower pass is the wrap.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_o && valid_i[i] && (i >= int'(ptr_i))) begin
        any_o       = 1'b1;
        idx_o       = IDX_W'(i);
        onehot_o[i] = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any_o && valid_i[i]) begin
        any_o       = 1'b1;
        idx_o       = IDX_W'(i);
        onehot_o[i] = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/imply_arbiter.sv
// Round-robin implication arbiter with duplicate merging and sticky
// same-cycle contradiction detection, feeding one assignment-memory write port.
module imply_arbiter
  import imply_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_EVAL,
  parameter int VAR_IDX_W = IMPL_VAR_W,
  parameter int CNT_W     = IMPL_CNT_W
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][VAR_IDX_W-1:0]  req_var,
  input  logic [NUM_REQ-1:0]                 req_val,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               wr_en,
  output logic [VAR_IDX_W-1:0]               wr_var,
  output logic                               wr_val,
  input  logic                               wr_ready,
  output logic                               conflict,
  output logic [VAR_IDX_W-1:0]               conflict_var,
  output logic [CNT_W-1:0]                   grant_cnt,
  output logic                               busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic                 wr_en_q, wr_en_d;
  logic [VAR_IDX_W-1:0] wr_var_q, wr_var_d;
  logic                 wr_val_q, wr_val_d;
  logic                 conflict_q, conflict_d;
  logic [VAR_IDX_W-1:0] conflict_var_q, conflict_var_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     grant_cnt_q, grant_cnt_d;

  logic [NUM_REQ-1:0]   win_onehot_s;
  logic [PTR_W-1:0]     win_idx_s;
  logic                 win_any_s;
  logic [VAR_IDX_W-1:0] win_var_s;
  logic                 win_val_s;
  logic                 pair_conflict_s;
  logic [VAR_IDX_W-1:0] pair_var_s;
  logic                 accept_s;
  logic                 grant_s;

  imply_arbiter_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_rr (
    .valid_i  (req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (win_onehot_s),
    .idx_o    (win_idx_s),
    .any_o    (win_any_s)
  );

  // Winner payload by one-hot mux.
  always_comb begin
    win_var_s = '0;
    win_val_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot_s[i]) begin
        win_var_s = win_var_s | req_var[i];
        win_val_s = win_val_s | req_val[i];
      end else begin
        win_var_s = win_var_s;
      end
    end
  end

  // Scan pairs in (i, j) order so the first hit is the lowest conflicting pair.
  always_comb begin
    pair_conflict_s = 1'b0;
    pair_var_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (!pair_conflict_s && req_valid[i] && req_valid[j] &&
            (req_var[i] == req_var[j]) && (req_val[i] != req_val[j])) begin
          pair_conflict_s = 1'b1;
          pair_var_s      = req_var[i];
        end else begin
          pair_conflict_s = pair_conflict_s;
        end
      end
    end
  end

  assign accept_s = !wr_en_q || wr_ready;
  assign grant_s  = win_any_s && accept_s && !reset && !flush &&
                    !conflict_q && !pair_conflict_s;

  // Merged duplicates are consumed alongside the winner.
  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_s && req_valid[j] && (req_var[j] == win_var_s) &&
          (req_val[j] == win_val_s)) begin
        req_ready[j] = 1'b1;
      end else begin
        req_ready[j] = 1'b0;
      end
    end
  end

  // Next-state for output register, conflict flag, pointer and counter.
  always_comb begin
    wr_en_d        = wr_en_q;
    wr_var_d       = wr_var_q;
    wr_val_d       = wr_val_q;
    conflict_d     = conflict_q;
    conflict_var_d = conflict_var_q;
    rr_ptr_d       = rr_ptr_q;
    grant_cnt_d    = grant_cnt_q;
    if (flush) begin
      wr_en_d        = 1'b0;
      conflict_d     = 1'b0;
      conflict_var_d = '0;
    end else begin
      if (grant_s) begin
        wr_en_d     = 1'b1;
        wr_var_d    = win_var_s;
        wr_val_d    = win_val_s;
        rr_ptr_d    = PTR_W'(wrap_inc(int'(win_idx_s), NUM_REQ));
        grant_cnt_d = (grant_cnt_q == {CNT_W{1'b1}}) ? grant_cnt_q
                                                     : grant_cnt_q + CNT_W'(1);
      end else if (wr_ready) begin
        wr_en_d = 1'b0;
      end else begin
        wr_en_d = wr_en_q;
      end
      if (pair_conflict_s && !conflict_q) begin
        conflict_d     = 1'b1;
        conflict_var_d = pair_var_s;
      end else begin
        conflict_d = conflict_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en_q        <= 1'b0;
      wr_var_q       <= '0;
      wr_val_q       <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
      rr_ptr_q       <= '0;
      grant_cnt_q    <= '0;
    end else begin
      wr_en_q        <= wr_en_d;
      wr_var_q       <= wr_var_d;
      wr_val_q       <= wr_val_d;
      conflict_q     <= conflict_d;
      conflict_var_q <= conflict_var_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_cnt_q    <= grant_cnt_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_var       = wr_var_q;
  assign wr_val       = wr_val_q;
  assign conflict     = conflict_q;
  assign conflict_var = conflict_var_q;
  assign grant_cnt    = grant_cnt_q;
  assign busy         = wr_en_q | (|req_valid);

endmodule

// File: tb/tb_imply_arbiter.sv
// Directed bench for imply_arbiter: expected writes are queued as requests are
// granted and popped by a monitor whenever the memory accepts a write.
module tb_imply_arbiter;
  import imply_arbiter_pkg::*;

  logic            clock = 1'b0;
  logic            reset, flush, wr_ready;
  logic [3:0]      req_valid, req_val, req_ready;
  logic [3:0][7:0] req_var;
  logic            wr_en, wr_val, conflict, busy;
  logic [7:0]      wr_var, conflict_var;
  logic [3:0]      grant_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  implication_t exp_q[$];

  imply_arbiter #(.NUM_REQ(4), .VAR_IDX_W(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_var(req_var), .req_val(req_val),
    .req_ready(req_ready), .wr_en(wr_en), .wr_var(wr_var), .wr_val(wr_val),
    .wr_ready(wr_ready), .conflict(conflict), .conflict_var(conflict_var),
    .grant_cnt(grant_cnt), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] v, input logic b);
    implication_t e;
    e.var_idx = v;
    e.val     = b;
    exp_q.push_back(e);
    exp_cnt = (exp_cnt >= 15) ? 15 : exp_cnt + 1;
  endtask

  // Memory-side monitor: every accepted write must match the next expectation.
  always @(negedge clock) begin
    if (reset === 1'b0 && wr_en === 1'b1 && wr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_pending", exp_q.size(), 1);
      end else begin
        implication_t e;
        e = exp_q.pop_front();
        chk("sb_wr_var", wr_var, e.var_idx);
        chk("sb_wr_val", wr_val, e.val);
      end
    end
  end

  initial begin
    int order[4];
    order = '{1, 2, 3, 0};

    // Reset with every requester active.
    reset = 1'b1; flush = 1'b0; wr_ready = 1'b1;
    req_valid = 4'hF; req_val = 4'hF;
    for (int i = 0; i < 4; i++) req_var[i] = 8'(i + 1);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_var", wr_var, 0);
      chk("rst_conflict", conflict, 0);
      chk("rst_conflict_var", conflict_var, 0);
      chk("rst_grant_cnt", grant_cnt, 0);
      chk("rst_req_ready", req_ready, 0);
    end
    reset = 1'b0;

    // Round robin across four distinct implications.
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("rr_ready", req_ready, 32'(1 << g));
      push(8'(g + 1), 1'b1);
      step();
      req_valid[g] = 1'b0;
      chk("rr_wr_en", wr_en, 1);
      chk("rr_wr_var", wr_var, 32'(g + 1));
    end
    chk("rr_grant_cnt", grant_cnt, 4);

    // Duplicate implications merge into one write.
    req_valid = 4'b0101; req_var[0] = 8'd5; req_var[2] = 8'd5; req_val = 4'b0101;
    #1;
    chk("merge_ready", req_ready, 32'b0101);
    push(8'd5, 1'b1);
    step();
    req_valid = 4'b0000;
    chk("merge_wr_var", wr_var, 5);
    chk("merge_grant_cnt", grant_cnt, 5);

    // Contradiction: var 7 implied both ways.
    req_valid = 4'b1011;
    req_var[0] = 8'd2; req_var[1] = 8'd7; req_var[3] = 8'd7;
    req_val = 4'b0011;
    #1;
    chk("cf_ready", req_ready, 0);
    step();
    chk("cf_flag", conflict, 1);
    chk("cf_var", conflict_var, 7);
    chk("cf_wr_en", wr_en, 0);
    chk("cf_grant_cnt", grant_cnt, 5);
    step();
    chk("cf_sticky", conflict, 1);
    chk("cf_ready_held", req_ready, 0);
    chk("cf_busy", busy, 1);
    flush = 1'b1;
    #1;
    chk("flush_ready", req_ready, 0);
    step();
    flush = 1'b0; req_valid = 4'b0000;
    chk("flush_conflict", conflict, 0);
    chk("flush_conflict_var", conflict_var, 0);
    chk("flush_grant_cnt", grant_cnt, 5);

    // Backpressure: pointer sits at 1, lone request 0 wins by wrapping.
    wr_ready = 1'b0;
    req_valid = 4'b0001; req_var[0] = 8'd9; req_val = 4'b0000;
    #1;
    chk("bp_first_ready", req_ready, 32'b0001);
    push(8'd9, 1'b0);
    step();
    req_valid = 4'hF; req_val = 4'hF;
    for (int i = 0; i < 4; i++) req_var[i] = 8'(10 + i);
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("bp_ready", req_ready, 0);
      chk("bp_wr_en", wr_en, 1);
      chk("bp_wr_var", wr_var, 9);
      step();
    end
    wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_rr_ready", req_ready, 32'(1 << order[k]));
      push(8'(10 + order[k]), 1'b1);
      step();
      req_valid[order[k]] = 1'b0;
      chk("bp_rr_wr_var", wr_var, 32'(10 + order[k]));
    end
    chk("bp_grant_cnt", grant_cnt, 10);

    // Flush while the memory accepts: write completes, no grant.
    flush = 1'b1;
    req_valid = 4'b0100; req_var[2] = 8'd20; req_val = 4'b0100;
    #1;
    chk("fw_ready", req_ready, 0);
    step();
    flush = 1'b0;
    chk("fw_wr_en", wr_en, 0);
    chk("fw_grant_cnt", grant_cnt, 10);
    #1;
    chk("fw_next_ready", req_ready, 32'b0100);
    push(8'd20, 1'b1);
    step();
    req_valid = 4'b0000;
    chk("fw_wr_var", wr_var, 20);

    // Counter saturation over a burst of back-to-back grants.
    for (int k = 0; k < 20; k++) begin
      req_valid = 4'b0001; req_var[0] = 8'(50 + k); req_val = 4'(k & 1);
      #1;
      chk("sat_ready", req_ready, 32'b0001);
      push(8'(50 + k), 1'(k & 1));
      step();
      chk("sat_grant_cnt", grant_cnt, exp_cnt);
    end
    req_valid = 4'b0000;
    step();
    chk("sat_drain", wr_en, 0);
    chk("sat_final_cnt", grant_cnt, 15);

    // Reset discards a stalled write and restores the pointer.
    wr_ready = 1'b0;
    req_valid = 4'b0010; req_var[1] = 8'd40; req_val = 4'b0010;
    #1;
    chk("mr_ready", req_ready, 32'b0010);
    step();
    req_valid = 4'b0000;
    chk("mr_wr_en", wr_en, 1);
    reset = 1'b1;
    step();
    reset = 1'b0; wr_ready = 1'b1; exp_cnt = 0;
    chk("mr_wr_en_clr", wr_en, 0);
    chk("mr_grant_cnt", grant_cnt, 0);
    req_valid = 4'b1001; req_var[0] = 8'd60; req_var[3] = 8'd61; req_val = 4'b1001;
    #1;
    chk("mr_ptr_ready", req_ready, 32'b0001);
    push(8'd60, 1'b1);
    step();
    req_valid = 4'b0000;
    chk("mr_grant_cnt_after", grant_cnt, exp_cnt);
    step();
    step();
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imply_arbiter.md
# imply_arbiter

Arbitrates implication requests from the parallel clause evaluators onto the single write port of the variable-assignment memory in the DPLL solver. Grants one implication per cycle round-robin and merges duplicate requests. Detects same-cycle contradictory implications and reports a sticky conflict to `control`, which resolves it by backtracking and flushing the arbiter.

## Interface
Parameters:
- `NUM_REQ`, 4: number of clause-evaluator requesters (≥2).
- `VAR_IDX_W`, 8: variable index width.
- `CNT_W`, 16: grant counter width.

Ports:
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: backtrack flush from `control`.
- `req_valid` input [NUM_REQ]: requester i has an implication.
- `req_var` input [NUM_REQ][VAR_IDX_W]: implied variable index.
- `req_val` input [NUM_REQ]: implied value (1 = true).
- `req_ready` output [NUM_REQ]: request i consumed this cycle (combinational).
- `wr_en` output 1: write valid to assignment memory (registered).
- `wr_var` output VAR_IDX_W: write index.
- `wr_val` output 1: write value.
- `wr_ready` input 1: memory accepts the write this cycle.
- `conflict` output 1: sticky contradiction flag.
- `conflict_var` output VAR_IDX_W: variable in conflict.
- `grant_cnt` output CNT_W: saturating count of issued writes.
- `busy` output 1: `wr_en | (|req_valid)`.

## Operation
- Output stage: one register (`wr_en/wr_var/wr_val`). `accept = !wr_en | wr_ready`.
- Arbitration: rotating pointer `rr_ptr`. Winner = first valid index at or after `rr_ptr`, wrapping modulo NUM_REQ.
- On grant: load output register with the winner; `rr_ptr <= winner+1` (wraps NUM_REQ-1 → 0); `grant_cnt` increments, saturating at all-ones.
- Merge: `req_ready[j]` asserts for the winner and every valid j with the same var and same value. Only one write issues.
- Conflict check: combinational over all valid pairs. If any pair has the same var and opposite values, no grant that cycle and all `req_ready` = 0. Next edge: `conflict <= 1`, `conflict_var` <= var of the lowest-indexed conflicting pair (lowest i, then lowest j).
- While `conflict` = 1: no grants, `req_ready` = 0, and the output register may still drain on `wr_ready`.
- `flush`: next edge clears `wr_en`, `conflict`, and `conflict_var`. `req_ready` = 0 in the flush cycle. `rr_ptr` and `grant_cnt` are preserved.
- Priority per cycle: reset > flush > conflict > grant.

## Timing
- Reset values: `wr_en`, `wr_var`, `wr_val`, `conflict`, `conflict_var`, `grant_cnt`, and `rr_ptr` are all 0.
- Latency: request granted in cycle N → `wr_en` = 1 in N+1.
- Throughput: one write per cycle while `wr_ready` is held at 1.
- Handshake:
  - A requester holds `req_valid/var/val` stable until it sees `req_ready`.
  - `wr_en/var/val` hold while `wr_en & !wr_ready`.
- Stall: `wr_en & !wr_ready` → `accept` = 0, all `req_ready` = 0, `rr_ptr` unchanged.
- Conflict and grant are never both produced in the same cycle.
- Flush in the same cycle as `wr_ready`: the write completes and the register clears; no new grant.
- Reset mid-operation: all state returns to reset values at the next edge. A pending write is discarded.
- Counter: `grant_cnt` counts grants into the output register, not memory acceptances, and does not wrap.

## Structure
- `sysdefs.svh` package holds `VAR_IDX_W`, `NUM_EVAL` (NUM_REQ source), and a `implication_t` struct {var, val}.
- Sub-module `rr_arbiter`: combinational rotating-priority pick (inputs valid vector and `rr_ptr`; outputs one-hot and index). `imply_arbiter` instantiates it and owns all registers, merge logic, and conflict logic.

## Test plan
- Reset: hold reset 2 cycles with all `req_valid` = 1 → all outputs 0, `req_ready` = 0.
- Round-robin with NUM_REQ=4, all valid, distinct vars 1..4 = true, `wr_ready` = 1:
  - Grants go 0,1,2,3 on consecutive cycles.
  - `wr_var` = 1,2,3,4 starting one cycle later.
  - `grant_cnt` = 4.
- Merge: req0 and req2 both imply var 5 = 1 → both `req_ready` = 1 in the same cycle, one write of (5,1), `grant_cnt` +1.
- Conflict: req1 var 7 = 1, req3 var 7 = 0, plus req0 var 2 = 1:
  - No `req_ready` that cycle.
  - Next cycle `conflict` = 1 and `conflict_var` = 7, stays set.
  - `flush` clears it one cycle later.
- Backpressure: `wr_ready` = 0 for 3 cycles with `wr_en` = 1 → output holds, `req_ready` = 0, `rr_ptr` unchanged. Release → the next grant is the pointer winner.
- Saturation: CNT_W=4, 20 grants → `grant_cnt` = 15.
